// File: rtl/piu_nextsrc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : piu_nextsrc_seq
//  Description : Registered next-source generator for the PIU patch-index
//                datapath. Accepts one command per cycle over a valid/ready
//                interface, computes next_pchlist / next_esmon / next_merged
//                for a NUM_PCHROW x NUM_PCHCOL patch grid and holds them in
//                output registers until the consumer takes them. A small
//                internal LIFO stores merged masks (SET_MERGED pushes,
//                COPY_MERGED pops). Overflow, underflow and reserved-opcode
//                conditions raise sticky error flags.
//
//  Ports       : clk, rst_n          clock, synchronous active-low reset
//                cmd_valid/cmd_ready command handshake
//                cmd_op              0 PASS, 1 TAKE_IN, 2 PREP, 3 SPLIT,
//                                    4 SET_MERGED, 5 COPY_MERGED, 6/7 reserved
//                sel_pchidxsrc       PASS routing (0 none, 1 list, 2 esmon,
//                                    3 merged)
//                pch_list            patch-list operand
//                next_pchidxsrc      PASS data
//                out_valid/out_ready result handshake
//                next_pchlist/next_esmon/next_merged  registered results
//                merged_cnt          LIFO occupancy
//                err_ovf/err_unf/err_op  sticky errors, cleared by err_clr
//
//  Revision    : 1.0  initial release
// ============================================================================
module piu_nextsrc_seq #(
    parameter int NUM_PCHROW   = 4,
    parameter int NUM_PCHCOL   = 4,
    parameter int MERGED_DEPTH = 4,
    localparam int NUM_PCH     = NUM_PCHROW * NUM_PCHCOL,
    localparam int CW          = $clog2(MERGED_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [1:0]         sel_pchidxsrc,
    input  logic [NUM_PCH-1:0] pch_list,
    input  logic [NUM_PCH-1:0] next_pchidxsrc,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_PCH-1:0] next_pchlist,
    output logic [NUM_PCH-1:0] next_esmon,
    output logic [NUM_PCH-1:0] next_merged,

    output logic [CW-1:0]      merged_cnt,
    output logic               err_ovf,
    output logic               err_unf,
    output logic               err_op,
    input  logic               err_clr
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_OP_PASS        = 3'd0;
    localparam logic [2:0] c_OP_TAKE_IN     = 3'd1;
    localparam logic [2:0] c_OP_PREP        = 3'd2;
    localparam logic [2:0] c_OP_SPLIT       = 3'd3;
    localparam logic [2:0] c_OP_SET_MERGED  = 3'd4;
    localparam logic [2:0] c_OP_COPY_MERGED = 3'd5;

    localparam logic [1:0] c_SEL_PCHLIST    = 2'd1;
    localparam logic [1:0] c_SEL_ESMON      = 2'd2;
    localparam logic [1:0] c_SEL_MERGED     = 2'd3;

    // LIFO address width; a single-entry LIFO still needs a 1-bit index.
    localparam int AW = (MERGED_DEPTH > 1) ? $clog2(MERGED_DEPTH) : 1;

    // PREP differs from SPLIT only in patch 1 being excluded.
    localparam logic [NUM_PCH-1:0] c_PREP_CLR = NUM_PCH'(2);

    localparam logic [CW-1:0] c_CNT_FULL = CW'(MERGED_DEPTH);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (NUM_PCHROW < 3) begin : g_chk_row
        $error("piu_nextsrc_seq: NUM_PCHROW must be >= 3");
    end
    if (NUM_PCHCOL < 4) begin : g_chk_col
        $error("piu_nextsrc_seq: NUM_PCHCOL must be >= 4");
    end
    if (MERGED_DEPTH < 1) begin : g_chk_depth
        $error("piu_nextsrc_seq: MERGED_DEPTH must be >= 1");
    end

    // ------------------------------------------------------------------------
    // Static grid masks. Each bit I sits at row I/NUM_PCHCOL, column
    // I%NUM_PCHCOL; the masks are pure functions of the grid geometry and
    // fold to constants in synthesis.
    // ------------------------------------------------------------------------
    logic [NUM_PCH-1:0] w_split_mask;      // PREP/SPLIT esmon pattern
    logic [NUM_PCH-1:0] w_prep_mask;
    logic [NUM_PCH-1:0] w_set_esmon_mask;  // SET_MERGED esmon pattern
    logic [NUM_PCH-1:0] w_set_force_mask;  // bits forced to 1 in next_merged

    for (genvar gi = 0; gi < NUM_PCH; gi++) begin : g_bit
        localparam int c_ROW  = gi / NUM_PCHCOL;
        localparam int c_COL  = gi % NUM_PCHCOL;
        localparam int c_LAST = NUM_PCHCOL - 1;

        assign w_split_mask[gi] =
              ((c_ROW == 0) && (c_COL != c_LAST))
           || ((c_ROW == 1) && ((c_COL == 0) || (c_COL == 1) || (c_COL == c_LAST)))
           || ((c_ROW == 2) && (c_COL >= 2) && (c_COL < c_LAST));

        assign w_set_esmon_mask[gi] =
              ((c_ROW == 0) && (c_COL != c_LAST))
           ||  (c_ROW == 1)
           || ((c_ROW == 2) && (c_COL >= 2) && (c_COL < c_LAST));

        assign w_set_force_mask[gi] =
               (c_ROW == 1) && (c_COL >= 2) && (c_COL < c_LAST);
    end

    assign w_prep_mask = w_split_mask & ~c_PREP_CLR;

    // ------------------------------------------------------------------------
    // Handshake / output-register state machine
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;

    assign out_valid = (r_state == ST_FULL);
    // Depends only on registered state and the consumer's ready, never on
    // cmd_valid, so the producer sees no combinational loop.
    assign cmd_ready = !out_valid || out_ready;
    assign w_accept  = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------------
    // Merged-mask LIFO
    // ------------------------------------------------------------------------
    logic [NUM_PCH-1:0] r_lifo [MERGED_DEPTH];
    logic [CW-1:0]      r_merged_cnt;
    logic [AW-1:0]      w_push_idx;
    logic [AW-1:0]      w_pop_idx;
    logic               w_lifo_full;
    logic               w_lifo_empty;

    assign w_lifo_full  = (r_merged_cnt == c_CNT_FULL);
    assign w_lifo_empty = (r_merged_cnt == '0);
    assign w_push_idx   = AW'(r_merged_cnt);
    assign w_pop_idx    = AW'(r_merged_cnt - c_CNT_ONE);

    // ------------------------------------------------------------------------
    // Result computation (evaluated every cycle, committed only on accept)
    // ------------------------------------------------------------------------
    logic [NUM_PCH-1:0] w_pchlist_d;
    logic [NUM_PCH-1:0] w_esmon_d;
    logic [NUM_PCH-1:0] w_merged_d;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf;
    logic               w_unf;
    logic               w_op_err;

    always_comb begin
        w_pchlist_d = '0;
        w_esmon_d   = '0;
        w_merged_d  = '0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ovf       = 1'b0;
        w_unf       = 1'b0;
        w_op_err    = 1'b0;

        case (cmd_op)
            c_OP_PASS: begin
                case (sel_pchidxsrc)
                    c_SEL_PCHLIST: w_pchlist_d = next_pchidxsrc;
                    c_SEL_ESMON:   w_esmon_d   = next_pchidxsrc;
                    c_SEL_MERGED:  w_merged_d  = next_pchidxsrc;
                    default:       ;
                endcase
            end
            c_OP_TAKE_IN: begin
                w_pchlist_d = pch_list;
            end
            c_OP_PREP: begin
                w_esmon_d = w_prep_mask;
            end
            c_OP_SPLIT: begin
                w_esmon_d = w_split_mask;
            end
            c_OP_SET_MERGED: begin
                w_esmon_d  = w_set_esmon_mask;
                w_merged_d = pch_list | w_set_force_mask;
                // A full LIFO still produces the result; only the push is lost.
                if (w_lifo_full) begin
                    w_ovf = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
            c_OP_COPY_MERGED: begin
                if (w_lifo_empty) begin
                    w_unf = 1'b1;
                end else begin
                    w_pop      = 1'b1;
                    w_merged_d = r_lifo[w_pop_idx];
                end
            end
            default: begin
                w_op_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Result registers: load on accept, otherwise hold (including after the
    // consumer takes them).
    // ------------------------------------------------------------------------
    logic [NUM_PCH-1:0] r_next_pchlist;
    logic [NUM_PCH-1:0] r_next_esmon;
    logic [NUM_PCH-1:0] r_next_merged;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_next_pchlist <= '0;
            r_next_esmon   <= '0;
            r_next_merged  <= '0;
        end else if (w_accept) begin
            r_next_pchlist <= w_pchlist_d;
            r_next_esmon   <= w_esmon_d;
            r_next_merged  <= w_merged_d;
        end
    end

    assign next_pchlist = r_next_pchlist;
    assign next_esmon   = r_next_esmon;
    assign next_merged  = r_next_merged;

    // LIFO storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept && w_push) begin
            r_lifo[w_push_idx] <= w_merged_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_merged_cnt <= '0;
        end else if (w_accept) begin
            if (w_push) begin
                r_merged_cnt <= r_merged_cnt + c_CNT_ONE;
            end else if (w_pop) begin
                r_merged_cnt <= r_merged_cnt - c_CNT_ONE;
            end
        end
    end

    assign merged_cnt = r_merged_cnt;

    // ------------------------------------------------------------------------
    // Sticky errors: a new error in the same cycle as err_clr wins.
    // ------------------------------------------------------------------------
    logic r_err_ovf;
    logic r_err_unf;
    logic r_err_op;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
            r_err_op  <= 1'b0;
        end else begin
            r_err_ovf <= (w_accept && w_ovf)    || (r_err_ovf && !err_clr);
            r_err_unf <= (w_accept && w_unf)    || (r_err_unf && !err_clr);
            r_err_op  <= (w_accept && w_op_err) || (r_err_op  && !err_clr);
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;
    assign err_op  = r_err_op;

endmodule
`default_nettype wire
